inst_mem_arbiter: RTL

INST_MEM_ARBITER -- requirements
Module: inst_mem_arbiter

---
 rtl/inst_mem_arbiter_pkg.sv | 26 ++
 rtl/inst_mem_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/inst_mem_arbiter_pkg.sv
// ============================================================================
// Module   : inst_mem_arbiter_pkg
// Purpose  : Shared bus widths, constants and response tag encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_mem_arbiter_pkg;

  localparam int INST_ADDR_W          = 32;
  localparam int INST_W               = 32;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  localparam logic [INST_W-1:0] ZERO_WORD    = '0;
  localparam logic              CHIP_ENABLE  = 1'b1;
  localparam logic              CHIP_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_LS   = 2'd2
  } tag_e;

endpackage

`default_nettype wire

// File: rtl/inst_mem_arbiter.sv
// ============================================================================
// Module   : inst_mem_arbiter
// Purpose  : Two-port (fetch / load) arbiter onto a one-cycle-latency
//            instruction memory, with fetch anti-starvation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [INST_ADDR_W-1:0] if_addr,
  output logic                   if_gnt,
  output logic                   if_rvalid,
  output logic [INST_W-1:0]      if_rdata,
  input  logic                   ls_req,
  input  logic [INST_ADDR_W-1:0] ls_addr,
  output logic                   ls_gnt,
  output logic                   ls_rvalid,
  output logic [INST_W-1:0]      ls_rdata,
  input  logic                   flush,
  output logic                   mem_ce,
  output logic [INST_ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0]      mem_rdata,
  output logic                   stall_req
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  tag_e             tag_q, tag_d;
  logic             flush_q, flush_d;
  logic             starved;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      tag_q        <= TAG_NONE;
      flush_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      tag_q        <= tag_d;
      flush_q      <= flush_d;
    end
  end

  always_comb begin
    starved  = (starve_cnt_q >= CNT_MAX);
    if_gnt   = 1'b0;
    ls_gnt   = 1'b0;
    // Load port wins conflicts until fetch has been denied long enough.
    if (!rst) begin
      if_gnt = if_req & (~ls_req | starved);
      ls_gnt = ls_req & ~if_gnt;
    end

    mem_ce   = (if_gnt | ls_gnt) ? CHIP_ENABLE : CHIP_DISABLE;
    mem_addr = ZERO_WORD;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (ls_gnt) begin
      mem_addr = ls_addr;
    end

    stall_req = if_req & ~if_gnt;

    starve_cnt_d = '0;
    if (if_req && !if_gnt) begin
      starve_cnt_d = starved ? CNT_MAX : starve_cnt_q + 1'b1;
    end

    tag_d = TAG_NONE;
    if (if_gnt) begin
      tag_d = TAG_IF;
    end else if (ls_gnt) begin
      tag_d = TAG_LS;
    end

    // Flush seen either in the grant cycle or the response cycle kills a fetch reply.
    flush_d   = flush;
    if_rvalid = (tag_q == TAG_IF) && !flush_q && !flush && !rst;
    ls_rvalid = (tag_q == TAG_LS) && !rst;
    if_rdata  = if_rvalid ? mem_rdata : ZERO_WORD;
    ls_rdata  = ls_rvalid ? mem_rdata : ZERO_WORD;
  end

endmodule

`default_nettype wire
